// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  // Address width for a bank of nregs registers; never narrower than one bit.
  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/reserve bus between the decode/writeback stages and regfile_mp.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives every field every cycle.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = calc_aw(NREGS)
);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking writebacks still in flight.
// Latency: set/clear/flush take effect at the next clk edge; lookups are combinational.
// Backpressure: none; priority is flush > reserve > write-clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: writes retire, a younger reserve re-arms, flush wipes everything.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    assign rd_busy[k] = busy[rd_addr[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / NWR-write integer register file with hard-wired x0 and write scoreboard.
// Latency: reads 0 cycles (combinational); writes and busy updates land on the next clk edge.
// Backpressure: none, all inputs sampled every edge. REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [NRD-1:0]  sb_busy;

  // Storage update; later ports are applied last so the highest index wins a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != AW'(ZERO_REG)))
          regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = bus.rd_addr[k*AW +: AW];

    // Read port mux; optional same-cycle forwarding, forced to zero while in reset.
    always_comb begin
      data = regs[addr];
      busy = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && (addr != AW'(ZERO_REG)) && (bus.wr_addr[p*AW +: AW] == addr)) begin
          data = bus.wr_data[p*XLEN +: XLEN];
          // A reserve in the same cycle means a younger producer is still pending.
          if (!(bus.rsv_en && (bus.rsv_addr == addr))) busy = 1'b0;
        end
      end
`endif
      if (!rst) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus.rd_data[k*XLEN +: XLEN] = data;
    assign bus.rd_busy[k]              = busy;
  end

endmodule
